// File: rtl/mem_arbiter.sv
// Single-CPU memory arbiter: serves icache reads and dcache reads/writes on one RAM port.
// Optional instruction-starvation guard enabled by defining MEM_ARB_FAIR_EN.

package cpu_types_pkg;
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;
endpackage

module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);
    import cpu_types_pkg::*;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_store;
    logic        r_wen;

    ramstate_t   w_rs;
    logic        w_dreq;
    logic        w_force_i;
    logic        w_go_d;
    logic        w_go_i;
    logic        w_imatch;
    logic        w_dmatch;
    logic        w_ilive;
    logic        w_dlive;
    logic        w_idone;
    logic        w_ddone;
    logic        w_iend;
    logic        w_dend;

    assign w_rs   = ramstate_t'(ramstate);
    assign w_dreq = dREN | dWEN;

`ifdef MEM_ARB_FAIR_EN
    logic [2:0] r_starve;

    assign w_force_i = iREN && (32'(r_starve) >= 32'(STARVE_MAX));

    // Counts data grants taken over a waiting icache; saturates at 7.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_starve <= 3'd0;
        end else if (w_go_d && iREN && (r_starve != 3'd7)) begin
            r_starve <= r_starve + 3'd1;
        end else if (w_go_i) begin
            r_starve <= 3'd0;
        end
    end
`else
    assign w_force_i = 1'b0 && (STARVE_MAX != 0);
`endif

    assign w_go_d = (r_state == IDLE) && w_dreq && !w_force_i;
    assign w_go_i = (r_state == IDLE) && iREN && !w_go_d;

    // A grant stays live only while the requester still presents the latched request.
    assign w_imatch = iREN && (iaddr == r_addr);
    assign w_dmatch = r_wen ? (dWEN && (daddr == r_addr) && (dstore == r_store))
                            : (dREN && (daddr == r_addr));

    assign w_ilive = (r_state == IGRANT) && w_imatch;
    assign w_dlive = (r_state == DGRANT) && w_dmatch;
    assign w_idone = w_ilive && (w_rs == ACCESS);
    assign w_ddone = w_dlive && (w_rs == ACCESS);
    assign w_iend  = !w_imatch || (w_rs == ACCESS) || (w_rs == ERROR);
    assign w_dend  = !w_dmatch || (w_rs == ACCESS) || (w_rs == ERROR);

    assign ramREN   = w_ilive || (w_dlive && !r_wen);
    assign ramWEN   = w_dlive && r_wen;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;

    assign iwait = !w_idone;
    assign dwait = !w_ddone;
    assign iload = w_idone ? ramload : 32'd0;
    assign dload = w_ddone ? ramload : 32'd0;

    // Grant state and request latches.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_addr  <= 32'd0;
            r_store <= 32'd0;
            r_wen   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_go_d) begin
                        r_state <= DGRANT;
                        r_addr  <= daddr;
                        r_store <= dstore;
                        r_wen   <= dWEN;
                    end else if (w_go_i) begin
                        r_state <= IGRANT;
                        r_addr  <= iaddr;
                    end
                end
                IGRANT: begin
                    if (w_iend) begin
                        r_state <= IDLE;
                    end
                end
                DGRANT: begin
                    if (w_dend) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (RAM side modelled by driving ramstate/ramload).

module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic test_reset();
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
        dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
        ramstate = RS_FREE; ramload = 32'h0;
        step(); step();
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL rst_iwait got=%b exp=1", iwait); end
        n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL rst_dwait got=%b exp=1", dwait); end
        n_checks++; if (iload !== 32'h0) begin n_fail++; $display("FAIL rst_iload got=%h exp=0", iload); end
        n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL rst_dload got=%h exp=0", dload); end
        n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got=%b exp=00", {ramREN, ramWEN}); end
        n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL rst_ramaddr got=%h exp=0", ramaddr); end
        n_checks++; if (ramstore !== 32'h0) begin n_fail++; $display("FAIL rst_ramstore got=%h exp=0", ramstore); end
        nRST = 1'b1;
        step();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rst_igrant_ren got=%b exp=1", ramREN); end
        n_checks++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL rst_igrant_addr got=%h exp=40", ramaddr); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL rst_igrant_wait got=%b exp=1", iwait); end
        ramstate = RS_ACCESS; ramload = 32'h8C220004;
        #1;
        n_checks++; if (iwait !== 1'b0) begin n_fail++; $display("FAIL rst_done_wait got=%b exp=0", iwait); end
        n_checks++; if (iload !== 32'h8C220004) begin n_fail++; $display("FAIL rst_done_load got=%h exp=8c220004", iload); end
        step();
        iREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL rst_idle_ren got=%b exp=0", ramREN); end
        n_checks++; if (iload !== 32'h0) begin n_fail++; $display("FAIL rst_idle_load got=%h exp=0", iload); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL rst_idle_wait got=%b exp=1", iwait); end
        step();
    endtask

    task automatic test_priority();
        iREN = 1'b1; iaddr = 32'h100;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
        step();
        n_checks++; if ({ramREN, ramWEN} !== 2'b01) begin n_fail++; $display("FAIL pri_wr_strobes got=%b exp=01", {ramREN, ramWEN}); end
        n_checks++; if (ramaddr !== 32'h200) begin n_fail++; $display("FAIL pri_wr_addr got=%h exp=200", ramaddr); end
        n_checks++; if (ramstore !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pri_wr_data got=%h exp=deadbeef", ramstore); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL pri_iwait got=%b exp=1", iwait); end
        ramstate = RS_ACCESS;
        #1;
        n_checks++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL pri_wr_done got=%b exp=0", dwait); end
        n_checks++; if (iload !== 32'h0) begin n_fail++; $display("FAIL pri_iload_other got=%h exp=0", iload); end
        step();
        dWEN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL pri_gap_strobes got=%b exp=00", {ramREN, ramWEN}); end
        step();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL pri_rd_ren got=%b exp=1", ramREN); end
        n_checks++; if (ramaddr !== 32'h100) begin n_fail++; $display("FAIL pri_rd_addr got=%h exp=100", ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'h12345678;
        #1;
        n_checks++; if (iload !== 32'h12345678) begin n_fail++; $display("FAIL pri_rd_load got=%h exp=12345678", iload); end
        step();
        iREN = 1'b0; ramstate = RS_FREE;
        step();
    endtask

    task automatic test_busy();
        dREN = 1'b1; daddr = 32'h300; ramload = 32'hA5A5A5A5;
        step();
        for (int k = 0; k < 5; k++) begin
            ramstate = RS_BUSY;
            #1;
            n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL busy_wait[%0d] got=%b exp=1", k, dwait); end
            n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL busy_load[%0d] got=%h exp=0", k, dload); end
            step();
        end
        ramstate = RS_ACCESS;
        #1;
        n_checks++; if (dwait !== 1'b0) begin n_fail++; $display("FAIL busy_done_wait got=%b exp=0", dwait); end
        n_checks++; if (dload !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL busy_done_load got=%h exp=a5a5a5a5", dload); end
        step();
        dREN = 1'b0; ramstate = RS_FREE;
        #1;
        n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL busy_after_load got=%h exp=0", dload); end
        step();
    endtask

    task automatic test_abort();
        iREN = 1'b1; iaddr = 32'h40;
        step();
        ramstate = RS_BUSY;
        #1;
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_pre_ren got=%b exp=1", ramREN); end
        iaddr = 32'h80;
        #1;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_ren got=%b exp=0", ramREN); end
        n_checks++; if (iwait !== 1'b1) begin n_fail++; $display("FAIL abort_wait got=%b exp=1", iwait); end
        step();
        ramstate = RS_FREE;
        #1;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL abort_idle_ren got=%b exp=0", ramREN); end
        step();
        n_checks++; if (ramaddr !== 32'h80) begin n_fail++; $display("FAIL abort_regrant_addr got=%h exp=80", ramaddr); end
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL abort_regrant_ren got=%b exp=1", ramREN); end
        ramstate = RS_ACCESS; ramload = 32'h00000BAD;
        #1;
        n_checks++; if (iload !== 32'h00000BAD) begin n_fail++; $display("FAIL abort_done_load got=%h exp=bad", iload); end
        step();
        iREN = 1'b0; ramstate = RS_FREE;
        step();
    endtask

    task automatic test_error();
        dREN = 1'b1; daddr = 32'h400;
        step();
        ramstate = RS_ERROR;
        #1;
        n_checks++; if (dwait !== 1'b1) begin n_fail++; $display("FAIL err_wait got=%b exp=1", dwait); end
        n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL err_load got=%h exp=0", dload); end
        step();
        ramstate = RS_FREE;
        #1;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL err_idle_ren got=%b exp=0", ramREN); end
        step();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL err_retry_ren got=%b exp=1", ramREN); end
        n_checks++; if (ramaddr !== 32'h400) begin n_fail++; $display("FAIL err_retry_addr got=%h exp=400", ramaddr); end
        ramstate = RS_ACCESS; ramload = 32'hCAFEF00D;
        #1;
        n_checks++; if (dload !== 32'hCAFEF00D) begin n_fail++; $display("FAIL err_done_load got=%h exp=cafef00d", dload); end
        step();
        dREN = 1'b0; ramstate = RS_FREE;
        step();
    endtask

    task automatic test_async_reset();
        dREN = 1'b1; daddr = 32'h500;
        step();
        n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL arst_pre_ren got=%b exp=1", ramREN); end
        nRST = 1'b0;
        #1;
        n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL arst_ren got=%b exp=0", ramREN); end
        n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL arst_addr got=%h exp=0", ramaddr); end
        dREN = 1'b0;
        step();
        nRST = 1'b1;
        step();
    endtask

    task automatic test_fairness();
        logic [31:0] grants[$];
        logic [31:0] exp_seq[6];
        nRST = 1'b0;
        iREN = 1'b1; iaddr = 32'h100;
        dREN = 1'b1; daddr = 32'h200;
        ramstate = RS_ACCESS; ramload = 32'h0;
        step();
        nRST = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            if (ramREN === 1'b1) grants.push_back(ramaddr);
        end
`ifdef MEM_ARB_FAIR_EN
        exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
`else
        exp_seq = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h200, 32'h200};
`endif
        n_checks++; if (grants.size() < 6) begin n_fail++; $display("FAIL fair_count got=%0d exp>=6", grants.size()); end
        for (int g = 0; g < 6; g++) begin
            if (g < grants.size()) begin
                n_checks++; if (grants[g] !== exp_seq[g]) begin n_fail++; $display("FAIL fair_grant[%0d] got=%h exp=%h", g, grants[g], exp_seq[g]); end
            end
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
        step();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_busy();
        test_abort();
        test_error();
        test_async_reset();
        test_fairness();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
